mem_write_checker: RTL

- Synthesizable, self-checking monitor on the core's data-memory write port (MemWrite/DataAdr/WriteData).
- Generalises the single-expected-store pass/fail check into a parametrised checker with:
  - a programmable expected-store table
  - ordered-sequence and final-store modes
  - an ignore address, a timeout and failure diagnostics
- Instantiated beside top in benches and on FPGA builds; drives a sticky verdict.

---
 rtl/mem_write_checker.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// Sticky pass/fail monitor for a data-memory write port: checks stores against a
// programmable table (final store or ordered sequence), with ignore address and timeout.
module mem_write_checker #(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter int            DEPTH      = 8,
  parameter int            MODE       = 0,
  parameter int            IGNORE_EN  = 1,
  parameter logic [AW-1:0] IGNORE_ADR = AW'(96),
  parameter int            TIMEOUT    = 1000,
  parameter int            CW         = 16,
  localparam int           IW         = $clog2(DEPTH),
  localparam int           LW         = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_adr,
  input  logic [DW-1:0] cfg_data,
  input  logic [LW-1:0] cfg_len,
  input  logic          start,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [2:0]    fail_code,
  output logic [IW-1:0] fail_idx,
  output logic [AW-1:0] fail_adr,
  output logic [DW-1:0] fail_data,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] cyc_count
);

  // state  | meaning
  // S_IDLE | after reset, waiting for the first start
  // S_RUN  | armed, judging writes and counting cycles
  // S_PASS | expected store(s) seen; verdict frozen until next start
  // S_FAIL | mismatch, timeout or bad length; diagnostics frozen
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [2:0] C_DATA = 3'd1;
  localparam logic [2:0] C_ADR  = 3'd2;
  localparam logic [2:0] C_TIME = 3'd3;
  localparam logic [2:0] C_CFG  = 3'd4;

  // A timeout beyond the saturated counter range can never be reached.
  localparam bit            TO_EN   = (TIMEOUT > 0) &&
                                      (longint'(TIMEOUT) <= (longint'(1) << CW));
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] tab_adr  [DEPTH];
  logic [DW-1:0] tab_data [DEPTH];
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          pass_d, fail_d;
  logic [2:0]    code_d;
  logic [IW-1:0] idx_d;
  logic [AW-1:0] fadr_d;
  logic [DW-1:0] fdata_d;
  logic [CW-1:0] wr_d, cyc_d;

  logic          len_bad, adr_hit, data_hit, ignored, last, to_hit;
  logic [IW-1:0] last_idx, tgt_idx;

  assign len_bad  = (len_q == '0) || (len_q > LW'(DEPTH));
  assign last_idx = IW'(len_q - LW'(1));
  assign tgt_idx  = (MODE == 0) ? last_idx : ptr_q;
  assign adr_hit  = (DataAdr == tab_adr[tgt_idx]);
  assign data_hit = (WriteData == tab_data[tgt_idx]);
  assign ignored  = (IGNORE_EN != 0) && (DataAdr == IGNORE_ADR) && !adr_hit;
  assign last     = (MODE == 0) || (ptr_q == last_idx);
  assign to_hit   = TO_EN && (cyc_count == TO_LAST);

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_PASS) || (state_q == S_FAIL);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    pass_d  = pass;
    fail_d  = fail;
    code_d  = fail_code;
    idx_d   = fail_idx;
    fadr_d  = fail_adr;
    fdata_d = fail_data;
    wr_d    = wr_count;
    cyc_d   = cyc_count;
    case (state_q)
      S_RUN: begin
        if (cyc_count != '1) cyc_d = cyc_count + CW'(1);
        if (len_bad) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          code_d  = C_CFG;
          idx_d   = ptr_q;
        end else begin
          if (MemWrite) begin
            if (wr_count != '1) wr_d = wr_count + CW'(1);
            if (!ignored) begin
              if (adr_hit && data_hit) begin
                if (last) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
                end else begin
                  ptr_d = ptr_q + IW'(1);
                end
              end else begin
                state_d = S_FAIL;
                fail_d  = 1'b1;
                code_d  = adr_hit ? C_DATA : C_ADR;
                idx_d   = ptr_q;
                fadr_d  = DataAdr;
                fdata_d = WriteData;
              end
            end
          end
          // A terminal write in the same cycle wins over the timeout.
          if ((state_d == S_RUN) && to_hit) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            code_d  = C_TIME;
            idx_d   = ptr_q;
            fadr_d  = '0;
            fdata_d = '0;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          len_d   = cfg_len;
          ptr_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = '0;
          idx_d   = '0;
          fadr_d  = '0;
          fdata_d = '0;
          wr_d    = '0;
          cyc_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      ptr_q     <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= '0;
      fail_idx  <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
      wr_count  <= '0;
      cyc_count <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      pass      <= pass_d;
      fail      <= fail_d;
      fail_code <= code_d;
      fail_idx  <= idx_d;
      fail_adr  <= fadr_d;
      fail_data <= fdata_d;
      wr_count  <= wr_d;
      cyc_count <= cyc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_adr[i]  <= '0;
        tab_data[i] <= '0;
      end
    end else if (cfg_we && (state_q != S_RUN)) begin
      tab_adr[cfg_idx]  <= cfg_adr;
      tab_data[cfg_idx] <= cfg_data;
    end
  end

endmodule
